// File: rtl/icache_nway_line.sv
// N-way set-associative instruction cache with multi-word lines and burst refill.
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_nway_line #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_SETS      = 64,
  parameter int unsigned ASSOCIATIVITY = 4,
  parameter int unsigned LINE_WORDS    = 4,
  parameter int unsigned REPL_POLICY   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_valid,
  output logic                  cache_hit,
  output logic                  cache_miss,
  output logic                  cache_evict
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned WB    = $clog2(LINE_WORDS);
  localparam int unsigned SB    = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_WIDTH - 2 - WB - SB;
  localparam int unsigned WI_W  = (WB > 0) ? WB : 1;
  localparam int unsigned WAY_W = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND, S_FLUSH} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]    data_q  [NUM_SETS][ASSOCIATIVITY][LINE_WORDS];
  logic [TAG_W-1:0]         tags_q  [NUM_SETS][ASSOCIATIVITY];
  logic [ASSOCIATIVITY-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0]         rr_q    [NUM_SETS];
  logic [DATA_WIDTH-1:0]    linebuf_q [LINE_WORDS];
  logic [7:0]               lfsr_q;
  logic [WI_W-1:0]          beat_q, word_l_q;
  logic [SB-1:0]            set_l_q, fset_q;
  logic [TAG_W-1:0]         tag_l_q;
  logic [WAY_W-1:0]         victim_q;
  logic                     victim_valid_q;
  logic [DATA_WIDTH-1:0]    cpu_data_q;
  logic                     cpu_valid_q, hit_q, miss_q, evict_q;

  logic [TAG_W-1:0] req_tag;
  logic [SB-1:0]    req_set;
  logic [WI_W-1:0]  req_word;
  logic             hit, found_inv;
  logic [WAY_W-1:0] hit_way, victim, policy_way;

  assign req_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_set = cpu_addr[2+WB +: SB];
  if (WB > 0) begin : g_widx
    assign req_word = cpu_addr[2 +: WB];
  end else begin : g_nowidx
    assign req_word = '0;
  end

  assign policy_way = (REPL_POLICY == 1) ?
                      ((ASSOCIATIVITY > 1) ? lfsr_q[WAY_W-1:0] : '0) : rr_q[req_set];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid_q[req_set][w] && tags_q[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way wins; the policy way is used only when the set is full.
  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
      if (!found_inv && !valid_q[req_set][w]) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) victim = policy_way;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (flush) state_d = S_FLUSH;
                 else if (cpu_req && !hit) state_d = S_REFILL;
      S_REFILL:  if (mem_valid && beat_q == WI_W'(LINE_WORDS - 1)) state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      S_FLUSH:   if (fset_q == SB'(NUM_SETS - 1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = !rst && (state_q == S_REFILL);
    cpu_stall = !rst && ((state_q != S_IDLE) || (cpu_req && (flush || !hit)));
  end

  assign mem_addr    = {tag_l_q, set_l_q, {(WB + 2){1'b0}}};
  assign cpu_data    = cpu_data_q;
  assign cpu_valid   = cpu_valid_q;
  assign cache_hit   = hit_q;
  assign cache_miss  = miss_q;
  assign cache_evict = evict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      lfsr_q         <= 8'h01;
      beat_q         <= '0;
      fset_q         <= '0;
      word_l_q       <= '0;
      set_l_q        <= '0;
      tag_l_q        <= '0;
      victim_q       <= '0;
      victim_valid_q <= 1'b0;
      cpu_data_q     <= '0;
      cpu_valid_q    <= 1'b0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      evict_q        <= 1'b0;
    end else begin
      lfsr_q      <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      cpu_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      evict_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            fset_q <= '0;
          end else if (cpu_req) begin
            if (hit) begin
              cpu_valid_q <= 1'b1;
              hit_q       <= 1'b1;
              cpu_data_q  <= data_q[req_set][hit_way][req_word];
            end else begin
              tag_l_q        <= req_tag;
              set_l_q        <= req_set;
              word_l_q       <= req_word;
              victim_q       <= victim;
              victim_valid_q <= !found_inv;
              beat_q         <= '0;
            end
          end
        end
        S_REFILL: begin
          if (mem_valid) begin
            linebuf_q[beat_q] <= mem_data;
            beat_q            <= beat_q + 1'b1;
          end
        end
        S_RESPOND: begin
          valid_q[set_l_q][victim_q] <= 1'b1;
          rr_q[set_l_q] <= (rr_q[set_l_q] == WAY_W'(ASSOCIATIVITY - 1)) ? '0 : rr_q[set_l_q] + 1'b1;
          cpu_valid_q   <= 1'b1;
          cpu_data_q    <= linebuf_q[word_l_q];
          miss_q        <= 1'b1;
          evict_q       <= victim_valid_q;
        end
        S_FLUSH: begin
          valid_q[fset_q] <= '0;
          rr_q[fset_q]    <= '0;
          fset_q          <= fset_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESPOND) begin
      tags_q[set_l_q][victim_q] <= tag_l_q;
      for (int unsigned i = 0; i < LINE_WORDS; i++)
        data_q[set_l_q][victim_q][i] <= linebuf_q[i];
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE && flush)) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_q && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_q && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
